// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the APB-UART transmit path.
//   - uart_state_e  : serializer FSM state encoding (also exported for debug)
//   - DATABUS_DEF   : default data width (matches the TX Fifo width)
//   - DIVW_DEF      : default width of the baud divisor
//   - NUM_DATA_BITS : data bits carried by one frame
//   - BIT_CNT_W     : width of the counter that walks data and stop bits
//   - is_on_line    : true for states whose timing is driven by the baud generator
package uart_pkg;

    localparam int DATABUS_DEF   = 8;
    localparam int DIVW_DEF      = 16;
    localparam int NUM_DATA_BITS = 8;
    localparam int BIT_CNT_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } uart_state_e;

    // States in which a frame bit is being driven on txd.
    function automatic logic is_on_line(uart_state_e s);
        return (s == ST_START) || (s == ST_DATA) ||
               (s == ST_PARITY) || (s == ST_STOP);
    endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if
//   Pop-side connection between the TX Fifo and the transmit serializer.
//   Signals:
//     fifo_empty : Fifo has no entry (driven by the Fifo)
//     fifo_rdata : Fifo read data, registered (driven by the Fifo)
//     fifo_pop   : one-cycle pop strobe (driven by the serializer)
//   Handshake: fifo_pop is a single-cycle request that is only raised when
//   fifo_empty was low; the popped byte appears on fifo_rdata in the cycle
//   that follows the strobe and the consumer captures it there. There is no
//   back-pressure from the Fifo: a pop of a non-empty Fifo always succeeds.
//   Modports:
//     master : serializer side (issues pops)
//     slave  : Fifo side (serves pops)
interface uart_tx_serializer_if #(
    parameter int DATABUS = 8
);
    logic               fifo_empty;
    logic [DATABUS-1:0] fifo_rdata;
    logic               fifo_pop;

    modport master (
        input  fifo_empty,
        input  fifo_rdata,
        output fifo_pop
    );

    modport slave (
        output fifo_empty,
        output fifo_rdata,
        input  fifo_pop
    );
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen
//   Bit-period timer for the transmit serializer. A down-counter is loaded
//   with the divisor and, while enabled, counts to zero; bit_tick marks the
//   last clk cycle of each bit period and the counter reloads there, so a
//   divisor of N yields a period of N+1 clk cycles.
//   Ports:
//     clk, rst_n : clock, synchronous active-low reset
//     en         : count while high (frame bit on the line)
//     load       : restart the period from div (frame start)
//     div        : bit period minus one, in clk cycles
//     bit_tick   : high in the final cycle of each bit period
module uart_baud_gen #(
    parameter int DIVW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            load,
    input  logic [DIVW-1:0] div,
    output logic            bit_tick
);

    logic [DIVW-1:0] cnt_q;
    logic [DIVW-1:0] cnt_d;

    always_comb begin
        bit_tick = en && (cnt_q == '0);
        cnt_d    = cnt_q;
        if (load) begin
            cnt_d = div;
        end else if (en) begin
            cnt_d = bit_tick ? div : (cnt_q - DIVW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   Transmit serializer of the APB-UART TX path. Pops one byte from the TX
//   Fifo while enabled and sends it as: start bit, 8 data bits LSB first,
//   optional parity bit, 1 or 2 stop bits. Frame configuration is captured
//   once per frame so register writes mid-frame only affect the next frame.
//   Ports:
//     clk, rst_n  : clock, synchronous active-low reset
//     tx_en       : transmitter enable
//     baud_div    : bit period minus one, in clk cycles
//     parity_en   : append a parity bit
//     parity_odd  : odd (1) / even (0) parity
//     stop2       : two stop bits when high
//     fifo_if     : TX Fifo pop port (master side)
//     txd         : serial line, idles high (registered)
//     busy        : high whenever the FSM is not in IDLE
//     tx_done     : one-cycle pulse after the last stop bit (registered)
//     state_dbg   : current FSM state
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATABUS = DATABUS_DEF,
    parameter int DIVW    = DIVW_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tx_en,
    input  logic [DIVW-1:0]        baud_div,
    input  logic                   parity_en,
    input  logic                   parity_odd,
    input  logic                   stop2,
    uart_tx_serializer_if.master   fifo_if,
    output logic                   txd,
    output logic                   busy,
    output logic                   tx_done,
    output uart_state_e            state_dbg
);

    uart_state_e            state_q,   state_d;
    logic [DATABUS-1:0]     shift_q,   shift_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DIVW-1:0]        div_q,     div_d;
    logic                   par_en_q,  par_en_d;
    logic                   stop2_q,   stop2_d;
    logic                   parity_q,  parity_d;
    logic                   txd_q,     txd_d;
    logic                   pop_q,     pop_d;
    logic                   done_q,    done_d;

    logic                   bit_tick;
    logic                   baud_load;
    logic                   baud_en;
    logic [DIVW-1:0]        baud_reload;
    logic                   can_fetch;

    // The divisor is latched in the same edge that starts the first bit
    // period, so the generator must take the live value while in LOAD.
    assign baud_reload = (state_q == ST_LOAD) ? baud_div : div_q;
    assign baud_en     = is_on_line(state_q);
    assign can_fetch   = tx_en && !fifo_if.fifo_empty;

    uart_baud_gen #(
        .DIVW (DIVW)
    ) u_baud_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (baud_en),
        .load     (baud_load),
        .div      (baud_reload),
        .bit_tick (bit_tick)
    );

    // Next-state and registered-output logic. txd/fifo_pop/tx_done are
    // computed one cycle ahead from the transition taken, so the flops
    // present them in the same cycle the new state becomes current.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        div_d     = div_q;
        par_en_d  = par_en_q;
        stop2_d   = stop2_q;
        parity_d  = parity_q;
        txd_d     = txd_q;
        pop_d     = 1'b0;
        done_d    = 1'b0;
        baud_load = 1'b0;

        case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                if (can_fetch) begin
                    state_d = ST_FETCH;
                    pop_d   = 1'b1;
                end
            end

            ST_FETCH: begin
                txd_d   = 1'b1;
                state_d = ST_LOAD;
            end

            ST_LOAD: begin
                shift_d   = fifo_if.fifo_rdata;
                div_d     = baud_div;
                par_en_d  = parity_en;
                stop2_d   = stop2;
                // Odd/even selection is folded into the stored bit, so the
                // polarity input itself need not be held for the frame.
                parity_d  = (^fifo_if.fifo_rdata) ^ parity_odd;
                bit_cnt_d = '0;
                baud_load = 1'b1;
                txd_d     = 1'b0;
                state_d   = ST_START;
            end

            ST_START: begin
                if (bit_tick) begin
                    txd_d   = shift_q[0];
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BIT_CNT_W'(NUM_DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        if (par_en_q) begin
                            txd_d   = parity_q;
                            state_d = ST_PARITY;
                        end else begin
                            txd_d   = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        // Next data bit is the one that becomes bit 0.
                        txd_d     = shift_q[1];
                    end
                end
            end

            ST_PARITY: begin
                if (bit_tick) begin
                    txd_d   = 1'b1;
                    state_d = ST_STOP;
                end
            end

            ST_STOP: begin
                txd_d = 1'b1;
                if (bit_tick) begin
                    // bit_cnt_q counts completed stop bits.
                    if (stop2_q && (bit_cnt_q == '0)) begin
                        bit_cnt_d = BIT_CNT_W'(1);
                    end else begin
                        bit_cnt_d = '0;
                        done_d    = 1'b1;
                        if (can_fetch) begin
                            state_d = ST_FETCH;
                            pop_d   = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end

            default: begin
                txd_d   = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            div_q     <= '0;
            par_en_q  <= 1'b0;
            stop2_q   <= 1'b0;
            parity_q  <= 1'b0;
            txd_q     <= 1'b1;
            pop_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            div_q     <= div_d;
            par_en_q  <= par_en_d;
            stop2_q   <= stop2_d;
            parity_q  <= parity_d;
            txd_q     <= txd_d;
            pop_q     <= pop_d;
            done_q    <= done_d;
        end
    end

    assign txd              = txd_q;
    assign fifo_if.fifo_pop = pop_q;
    assign tx_done          = done_q;
    assign busy             = (state_q != ST_IDLE);
    assign state_dbg        = state_q;

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Transmit serializer of the APB-UART TX path. Sits directly downstream of the TX Fifo.
- Pops one byte whenever the Fifo is non-empty and transmission is enabled, then shifts it out on txd as an asynchronous frame: start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits.
- Bit timing comes from a programmable clock divisor driven by the APB register block.

Parameters:
- DATABUS, 8, data width; must match the TX Fifo push/pop width.
- DIVW, 16, width of the baud divisor input.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- tx_en  input  1  transmitter enable from the control register.
- baud_div  input  DIVW  bit period minus one, in clk cycles.
- parity_en  input  1  1 = append a parity bit.
- parity_odd  input  1  1 = odd parity, 0 = even parity.
- stop2  input  1  1 = two stop bits, 0 = one stop bit.
- fifo_empty  input  1  TX Fifo empty flag.
- fifo_rdata  input  DATABUS  TX Fifo pop_data_out; registered, valid the cycle after fifo_pop.
- fifo_pop  output  1  one-cycle pop strobe to the TX Fifo.
- txd  output  1  serial line; idles high.
- busy  output  1  high in every state except IDLE.
- tx_done  output  1  one-cycle pulse at the end of the last stop bit.

Behaviour:
- Reset: state=IDLE, txd=1, fifo_pop=0, busy=0, tx_done=0, shift register=0, bit counter=0, baud counter=0. Reset asserted mid-frame aborts the frame; txd=1 from the next edge. The aborted byte is lost.
- Bit period: baud_div+1 clk cycles. baud_div=0 gives 1 cycle per bit.
- Baud counter: reloads at each bit boundary and counts down to 0.
- Configuration sampling: baud_div, parity_en, parity_odd and stop2 are latched in LOAD and held for the whole frame. Changes mid-frame have no effect until the next frame.
- FSM states: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE: txd=1. If tx_en=1 and fifo_empty=0, go to FETCH.
- FETCH: fifo_pop=1 for exactly this cycle. Go to LOAD.
- LOAD: capture fifo_rdata into the shift register, latch configuration, compute parity. Go to START.
- START: txd=0 for one bit period. Go to DATA.
- DATA: txd = shift register bit 0. The register shifts right at each bit boundary. After 8 bits: go to PARITY if parity_en, else STOP.
- PARITY: txd = XOR of the data bits, XORed with parity_odd. One bit period, then STOP.
- STOP: txd=1 for 1 or 2 bit periods (stop2). At the final boundary, tx_done=1 for one cycle, then:
  - go to FETCH if tx_en=1 and fifo_empty=0 (back-to-back; FETCH and LOAD add 2 idle-high clk cycles between frames),
  - otherwise go to IDLE.
- tx_en deasserted mid-frame: the current frame completes normally, then the FSM returns to IDLE. No further pops.
- fifo_pop is never asserted while fifo_empty=1. Only FETCH pops, and FETCH is entered only when fifo_empty=0.
- Latency: the edge after IDLE sees a non-empty Fifo, fifo_pop rises. txd falls two edges after that.
- txd, fifo_pop and tx_done are registered outputs (no combinational path from inputs).
- Frame length in clk cycles: (baud_div+1) × (10 + parity_en + stop2).

Decomposition:
- Shared package uart_pkg:
  - FSM state enum;
  - DATABUS and DIVW defaults;
  - NUM_DATA_BITS=8.
- One sub-module, uart_baud_gen:
  - inputs: divisor reload, enable;
  - output: one-cycle bit_tick at each bit boundary.
- FSM, shift register and parity logic stay in uart_tx_serializer.

Test Plan:
- Reset and idle: hold rst_n=0 for 2 cycles with fifo_empty=1 -> txd=1, busy=0, fifo_pop=0. These hold for 50 cycles after reset release.
- Basic frame: baud_div=3, no parity, 1 stop, Fifo holds 0xA5 ->
  - fifo_pop high exactly 1 cycle;
  - txd sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 clk;
  - total 40 clk, tx_done pulses once, busy falls the next cycle.
- Parity and stop bits: 0xA5 with even parity -> parity bit 0. Odd parity with stop2 -> parity bit 1, then 2 stop bits; frame is 12×4=48 clk.
- Back-to-back: push 0x01, 0x02, 0x03 with baud_div=0 ->
  - 3 pops;
  - frames separated by exactly 2 idle-high cycles;
  - decoded bytes are 0x01, 0x02, 0x03 in order;
  - fifo_pop never asserted while fifo_empty=1.
- Mid-frame changes:
  - change baud_div from 3 to 7 during DATA -> the current frame keeps 4 clk/bit and the next frame uses 8 clk/bit;
  - drop tx_en during DATA -> the frame completes and no further pop occurs.
- Reset mid-frame: assert rst_n=0 during bit 4 of a frame -> txd=1 and busy=0 after the next edge. After release, the FSM resumes from IDLE and pops the next Fifo entry.
